// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source inputs and pipeline-register controls exchanged between the
// pipeline datapath (master) and the stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       id_rs;
  logic [2:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [2:0]       ex_rd;
  logic             ex_RegWrite;
  logic             ex_MemToReg;
  logic [2:0]       mem_rd;
  logic             mem_RegWrite;
  logic             br_taken;
  logic             imem_stall;
  logic             dmem_stall;
  logic             wb_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_stall;
  logic             exmem_en;
  logic             memwb_en;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_RegWrite, ex_MemToReg,
           mem_rd, mem_RegWrite, br_taken, imem_stall, dmem_stall, wb_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_stall, exmem_en, memwb_en,
           halted, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_RegWrite, ex_MemToReg,
           mem_rd, mem_RegWrite, br_taken, imem_stall, dmem_stall, wb_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_stall, exmem_en, memwb_en,
           halted, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: resolves hazard sources into
// per-register enables/bubbles, tracks dmem wait timeout and halt, counts stalls/flushes.
module pipe_hazard_ctrl #(
  parameter int FORWARD = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz
);

  typedef enum logic [1:0] {S_RUN, S_FREEZE, S_HALTED} state_t;

  state_t           state_q, state_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic raw_ex, raw_mem, lu, dstall;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_stall, exmem_en, memwb_en;

  assign raw_ex  = hz.ex_RegWrite  & ((hz.id_use_rs & (hz.id_rs == hz.ex_rd)) |
                                      (hz.id_use_rt & (hz.id_rt == hz.ex_rd)));
  assign raw_mem = hz.mem_RegWrite & ((hz.id_use_rs & (hz.id_rs == hz.mem_rd)) |
                                      (hz.id_use_rt & (hz.id_rt == hz.mem_rd)));
  assign lu      = raw_ex & hz.ex_MemToReg;
  assign dstall  = (FORWARD != 0) ? lu : (raw_ex | raw_mem);

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_stall  = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;

    if (state_q == S_HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (hz.dmem_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      // fcnt holds the number of consecutive dmem wait cycles seen so far
      if (state_q == S_RUN) begin
        state_d = S_FREEZE;
        fcnt_d  = 8'd1;
      end else if (fcnt_q == 8'(TIMEOUT - 1)) begin
        state_d = S_HALTED;
        err_d   = 1'b1;
      end else begin
        fcnt_d  = fcnt_q + 8'd1;
      end
    end else begin
      state_d = hz.wb_halt ? S_HALTED : S_RUN;
      fcnt_d  = 8'd0;
      if (hz.br_taken) begin
        ifid_flush = 1'b1;
        idex_stall = 1'b1;
        if (flush_cnt_q != {CNT_W{1'b1}})
          flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (dstall) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_stall = 1'b1;
      end else if (hz.imem_stall) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end

    if ((state_q != S_HALTED) && !pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      fcnt_q      <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_en    = idex_en;
  assign hz.idex_stall = idex_stall;
  assign hz.exmem_en   = exmem_en;
  assign hz.memwb_en   = memwb_en;
  assign hz.halted     = (state_q == S_HALTED);
  assign hz.err        = err_q;
  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: one forwarding controller (TIMEOUT=4, 4-bit counters) and one
// non-forwarding controller (defaults) share the same hazard stimulus.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_NORM = 7'b1101011; // pc,ifid_en,ifid_fl,idex_en,idex_st,exmem,memwb
  localparam logic [6:0] C_DST  = 7'b0001111;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_IMEM = 7'b0111011;
  localparam logic [6:0] C_FRZ  = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4))  hf ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) hn ();

  assign hn.id_rs        = hf.id_rs;
  assign hn.id_rt        = hf.id_rt;
  assign hn.id_use_rs    = hf.id_use_rs;
  assign hn.id_use_rt    = hf.id_use_rt;
  assign hn.ex_rd        = hf.ex_rd;
  assign hn.ex_RegWrite  = hf.ex_RegWrite;
  assign hn.ex_MemToReg  = hf.ex_MemToReg;
  assign hn.mem_rd       = hf.mem_rd;
  assign hn.mem_RegWrite = hf.mem_RegWrite;
  assign hn.br_taken     = hf.br_taken;
  assign hn.imem_stall   = hf.imem_stall;
  assign hn.dmem_stall   = hf.dmem_stall;
  assign hn.wb_halt      = hf.wb_halt;

  pipe_hazard_ctrl #(.FORWARD(1), .TIMEOUT(4), .CNT_W(4)) dut_f (
    .clk (clk),
    .rst (rst),
    .hz  (hf)
  );

  pipe_hazard_ctrl #(.FORWARD(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .hz  (hn)
  );

  function automatic logic [6:0] ctl_f();
    return {hf.pc_en, hf.ifid_en, hf.ifid_flush, hf.idex_en, hf.idex_stall, hf.exmem_en, hf.memwb_en};
  endfunction

  function automatic logic [6:0] ctl_n();
    return {hn.pc_en, hn.ifid_en, hn.ifid_flush, hn.idex_en, hn.idex_stall, hn.exmem_en, hn.memwb_en};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear();
    hf.id_rs = 3'd0; hf.id_rt = 3'd0; hf.id_use_rs = 1'b0; hf.id_use_rt = 1'b0;
    hf.ex_rd = 3'd0; hf.ex_RegWrite = 1'b0; hf.ex_MemToReg = 1'b0;
    hf.mem_rd = 3'd0; hf.mem_RegWrite = 1'b0;
    hf.br_taken = 1'b0; hf.imem_stall = 1'b0; hf.dmem_stall = 1'b0; hf.wb_halt = 1'b0;
  endtask

  // inputs change 1 time unit after the rising edge; combinational outputs are
  // checked mid-cycle, registered outputs right after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  initial begin
    rst = 1'b1;
    clear();
    cyc();
    cyc();
    rst = 1'b0;

    mid();
    chk("rst_ctl_f", 32'(ctl_f()), 32'(C_NORM));
    chk("rst_ctl_n", 32'(ctl_n()), 32'(C_NORM));
    chk("rst_halted", 32'(hf.halted), 32'd0);
    chk("rst_err", 32'(hf.err), 32'd0);
    chk("rst_stall", 32'(hf.stall_cnt), 32'd0);
    chk("rst_flush", 32'(hf.flush_cnt), 32'd0);
    cyc();

    // load-use in ID vs EX
    hf.ex_RegWrite = 1'b1; hf.ex_MemToReg = 1'b1; hf.ex_rd = 3'd3;
    hf.id_rs = 3'd3; hf.id_use_rs = 1'b1;
    mid();
    chk("lu_ctl_f", 32'(ctl_f()), 32'(C_DST));
    chk("lu_ctl_n", 32'(ctl_n()), 32'(C_DST));
    cyc();
    chk("lu_stall_f", 32'(hf.stall_cnt), 32'd1);

    // plain ALU RAW: forwarding hides it, no-forwarding stalls
    hf.ex_MemToReg = 1'b0;
    mid();
    chk("alu_raw_f", 32'(ctl_f()), 32'(C_NORM));
    chk("alu_raw_n", 32'(ctl_n()), 32'(C_DST));
    cyc();
    clear();

    // RAW against MEM on rt
    hf.mem_RegWrite = 1'b1; hf.mem_rd = 3'd5; hf.id_rt = 3'd5; hf.id_use_rt = 1'b1;
    mid();
    chk("mraw_n", 32'(ctl_n()), 32'(C_DST));
    chk("mraw_f", 32'(ctl_f()), 32'(C_NORM));
    cyc();
    hf.id_use_rt = 1'b0;
    mid();
    chk("mraw_nouse_n", 32'(ctl_n()), 32'(C_NORM));
    cyc();
    chk("mraw_stall_n", 32'(hn.stall_cnt), 32'd3);
    clear();

    // branch overrides load-use and imem stall
    hf.ex_RegWrite = 1'b1; hf.ex_MemToReg = 1'b1; hf.ex_rd = 3'd3;
    hf.id_rs = 3'd3; hf.id_use_rs = 1'b1; hf.imem_stall = 1'b1; hf.br_taken = 1'b1;
    mid();
    chk("br_ctl_f", 32'(ctl_f()), 32'(C_BR));
    cyc();
    chk("br_flush_f", 32'(hf.flush_cnt), 32'd1);
    chk("br_stall_f", 32'(hf.stall_cnt), 32'd1);
    clear();

    // dmem wait with pending branch: 3 frozen cycles, then the redirect fires
    for (int i = 0; i < 3; i++) begin
      hf.dmem_stall = 1'b1; hf.br_taken = 1'b1;
      mid();
      chk($sformatf("dm_frz%0d", i), 32'(ctl_f()), 32'(C_FRZ));
      cyc();
    end
    chk("dm_stall_f", 32'(hf.stall_cnt), 32'd4);
    chk("dm_flush_hold", 32'(hf.flush_cnt), 32'd1);
    hf.dmem_stall = 1'b0;
    mid();
    chk("dm_br_ctl", 32'(ctl_f()), 32'(C_BR));
    cyc();
    chk("dm_br_flush", 32'(hf.flush_cnt), 32'd2);
    chk("dm_no_halt", 32'(hf.halted), 32'd0);
    clear();

    // imem stall bubbles; 4-bit counter saturates, 16-bit one keeps counting
    for (int i = 0; i < 20; i++) begin
      hf.imem_stall = 1'b1;
      if (i == 0) begin
        mid();
        chk("imem_ctl_f", 32'(ctl_f()), 32'(C_IMEM));
      end
      cyc();
    end
    chk("sat_stall_f", 32'(hf.stall_cnt), 32'd15);
    chk("cnt_stall_n", 32'(hn.stall_cnt), 32'd26);
    clear();

    // dmem timeout with TIMEOUT=4
    for (int i = 0; i < 6; i++) begin
      hf.dmem_stall = 1'b1;
      mid();
      chk($sformatf("to_frz%0d", i), 32'(ctl_f()), 32'(C_FRZ));
      cyc();
      if (i == 2) chk("to_halt_c3", 32'(hf.halted), 32'd0);
      if (i == 3) begin
        chk("to_halt_c4", 32'(hf.halted), 32'd1);
        chk("to_err_c4", 32'(hf.err), 32'd1);
      end
    end
    chk("to_err_n", 32'(hn.err), 32'd0);
    chk("to_halt_n", 32'(hn.halted), 32'd0);
    chk("to_stall_sat", 32'(hf.stall_cnt), 32'd15);
    clear();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_halted", 32'(hf.halted), 32'd0);
    chk("rst2_err", 32'(hf.err), 32'd0);
    chk("rst2_stall", 32'(hf.stall_cnt), 32'd0);
    mid();
    chk("rst2_ctl", 32'(ctl_f()), 32'(C_NORM));
    cyc();

    // one stall, then halt: halt cycle advances normally, afterwards frozen
    hf.imem_stall = 1'b1;
    cyc();
    clear();
    hf.wb_halt = 1'b1;
    mid();
    chk("halt_cyc_ctl", 32'(ctl_f()), 32'(C_NORM));
    cyc();
    chk("halt_halted", 32'(hf.halted), 32'd1);
    chk("halt_err", 32'(hf.err), 32'd0);
    clear();
    for (int i = 0; i < 3; i++) begin
      hf.br_taken = 1'b1; hf.imem_stall = 1'b1;
      mid();
      chk($sformatf("halt_ctl%0d", i), 32'(ctl_f()), 32'(C_FRZ));
      chk($sformatf("halt_fl%0d", i), 32'({hf.ifid_flush, hf.idex_stall}), 32'd0);
      cyc();
    end
    chk("halt_stall_frz", 32'(hf.stall_cnt), 32'd1);
    chk("halt_flush_frz", 32'(hf.flush_cnt), 32'd0);
    chk("halt_still", 32'(hf.halted), 32'd1);
    clear();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
